// File: rtl/fifo_burst_arbiter.sv
// fifo_burst_arbiter
// Round-robin arbiter that lets NUM_SRC byte-stream sources share one FIFO
// write port. Each grant writes a framed burst: header {4'hA,2'b00,id},
// up to BURST_MAX payload bytes, and optionally a trailer byte holding the
// payload count. A grant is only issued when the FIFO has room for a whole
// worst-case burst plus one in-flight write.
// Define FIFO_ARB_TRAILER_EN to enable the trailer byte.
module fifo_burst_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int BURST_MAX = 16,
    parameter int ADDR_W    = 11
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_ack,
    input  logic [ADDR_W-1:0]    addr_in,
    input  logic [ADDR_W-1:0]    addr_out_sync,
    output logic [7:0]           fifo_data,
    output logic                 fifo_write,
    output logic [1:0]           grant_id,
    output logic                 busy
);

`ifdef FIFO_ARB_TRAILER_EN
    localparam int NEED = BURST_MAX + 3;
    typedef enum logic [1:0] {IDLE, HEADER, DATA, TRAILER} state_t;
`else
    localparam int NEED = BURST_MAX + 2;
    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
`endif

    state_t            state;
    state_t            state_next;
    logic [1:0]        last_grant;
    logic [7:0]        count;
    logic [ADDR_W-1:0] used;
    logic [ADDR_W-1:0] free;
    logic              space_ok;
    logic [1:0]        win;
    logic              win_found;
    logic              sel_valid;
    logic              sel_last;
    logic [7:0]        sel_data;
    logic              count_hit;
    logic              wr_next;
    logic [7:0]        data_next;

    // Modulo pointer difference; all-ones minus used is simply its inverse.
    assign used      = addr_in - addr_out_sync;
    assign free      = ~used;
    assign space_ok  = (32'(free) >= NEED);
    assign count_hit = (({1'b0, count} + 9'd1) == 9'(BURST_MAX));

    // Round-robin winner search and selection of the granted source's lane.
    always_comb begin
        win       = 2'd0;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (!win_found && src_valid[(int'(last_grant) + k) % NUM_SRC]) begin
                win       = 2'((int'(last_grant) + k) % NUM_SRC);
                win_found = 1'b1;
            end
        end
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = 8'h00;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_id == 2'(i)) begin
                sel_valid = src_valid[i];
                sel_last  = src_last[i];
                sel_data  = src_data[8*i +: 8];
            end
        end
    end

    // State register plus registered FIFO outputs, grant tracking and payload count.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state      <= IDLE;
            fifo_write <= 1'b0;
            fifo_data  <= 8'h00;
            grant_id   <= 2'd0;
            busy       <= 1'b0;
            last_grant <= 2'(NUM_SRC - 1);
            count      <= 8'd0;
        end else begin
            state      <= state_next;
            fifo_write <= wr_next;
            fifo_data  <= data_next;
            busy       <= (state_next != IDLE);
            if (state == IDLE && state_next == HEADER) begin
                grant_id   <= win;
                last_grant <= win;
                count      <= 8'd0;
            end else if (state == DATA && sel_valid) begin
                count <= count + 8'd1;
            end
        end
    end

    // Next-state logic: a burst ends on last byte, full count, or a dropped valid.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (win_found && space_ok) begin
                    state_next = HEADER;
                end
            end
            HEADER: state_next = DATA;
            DATA: begin
                if (!sel_valid || sel_last || count_hit) begin
`ifdef FIFO_ARB_TRAILER_EN
                    state_next = TRAILER;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef FIFO_ARB_TRAILER_EN
            TRAILER: state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // Output logic: ack the granted lane in DATA and choose the byte written next edge.
    always_comb begin
        src_ack   = '0;
        wr_next   = 1'b0;
        data_next = fifo_data;
        case (state)
            HEADER: begin
                wr_next   = 1'b1;
                data_next = {4'hA, 2'b00, grant_id};
            end
            DATA: begin
                if (sel_valid && !reset) begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        src_ack[i] = (grant_id == 2'(i));
                    end
                    wr_next   = 1'b1;
                    data_next = sel_data;
                end
            end
`ifdef FIFO_ARB_TRAILER_EN
            TRAILER: begin
                wr_next   = 1'b1;
                data_next = count;
            end
`endif
            default: begin
                wr_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_burst_arbiter.sv
// tb_fifo_burst_arbiter
// Directed bench for fifo_burst_arbiter: a cycle table for the single-source
// and dropped-valid bursts, plus hand-written sequences for space limits,
// reset mid-burst, round-robin rotation (BURST_MAX=4 instance) and trailer.
// Expected trailer bytes follow FIFO_ARB_TRAILER_EN when it is defined.
module tb_fifo_burst_arbiter;

`ifdef FIFO_ARB_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic [3:0]  exp_ack;
        logic        exp_wr;
        logic [7:0]  exp_data;
        logic        exp_busy;
        logic [1:0]  exp_gid;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [3:0]  src_valid;
    logic [31:0] src_data;
    logic [3:0]  src_last;
    logic [10:0] addr_in;
    logic [10:0] addr_out_sync;

    logic [3:0]  ack;
    logic [7:0]  fd;
    logic        fw;
    logic [1:0]  gid;
    logic        bsy;

    logic [3:0]  ack4;
    logic [7:0]  fd4;
    logic        fw4;
    logic [1:0]  gid4;
    logic        bsy4;

    int total = 0;
    int bad   = 0;

    vec_t       tbl[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] pay6[5];

    always #5 clk_in = ~clk_in;

    fifo_burst_arbiter #(.NUM_SRC(4), .BURST_MAX(16), .ADDR_W(11)) dut (
        .clk_in(clk_in), .reset(reset),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
        .src_ack(ack), .addr_in(addr_in), .addr_out_sync(addr_out_sync),
        .fifo_data(fd), .fifo_write(fw), .grant_id(gid), .busy(bsy)
    );

    fifo_burst_arbiter #(.NUM_SRC(4), .BURST_MAX(4), .ADDR_W(11)) dut4 (
        .clk_in(clk_in), .reset(reset),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
        .src_ack(ack4), .addr_in(addr_in), .addr_out_sync(addr_out_sync),
        .fifo_data(fd4), .fifo_write(fw4), .grant_id(gid4), .busy(bsy4)
    );

    function automatic vec_t mk(logic [3:0] v, logic [31:0] d, logic [3:0] l,
                                logic [3:0] a, logic w, logic [7:0] dd,
                                logic b, logic [1:0] g);
        vec_t r;
        r.valid = v;  r.data = d;  r.last = l;  r.exp_ack = a;
        r.exp_wr = w; r.exp_data = dd; r.exp_busy = b; r.exp_gid = g;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        src_valid = v.valid;
        src_data  = v.data;
        src_last  = v.last;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic tickCollect();
        tick();
        if (fw) got_q.push_back(fd);
    endtask

    task automatic compareQueues(input string name);
        checkOutput({name, ".count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checkOutput($sformatf("%s.byte%0d", name, i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
        end
    endtask

    task automatic resetBoth();
        reset = 1'b1;
        src_valid = 4'h0; src_last = 4'h0; src_data = 32'h0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int k;
        logic acked;
        reset = 1'b1;
        src_valid = 4'h0; src_data = 32'h0; src_last = 4'h0;
        addr_in = 11'd0; addr_out_sync = 11'd0;
        tick();
        tick();
        checkOutput("reset.fifo_write", fw, 0);
        checkOutput("reset.fifo_data", fd, 0);
        checkOutput("reset.grant_id", gid, 0);
        checkOutput("reset.busy", bsy, 0);
        checkOutput("reset.src_ack", ack, 0);
        reset = 1'b0;

        // Source 2 three-byte burst, then source 1 drops valid mid-burst, then source 3 zero-payload.
        tbl.push_back(mk(4'h4, 32'h0011_0000, 4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 2'd2));
        tbl.push_back(mk(4'h4, 32'h0011_0000, 4'h0, 4'h0, 1'b1, 8'hA2, 1'b1, 2'd2));
        tbl.push_back(mk(4'h4, 32'h0011_0000, 4'h0, 4'h4, 1'b1, 8'h11, 1'b1, 2'd2));
        tbl.push_back(mk(4'h4, 32'h0022_0000, 4'h0, 4'h4, 1'b1, 8'h22, 1'b1, 2'd2));
        tbl.push_back(mk(4'h4, 32'h0033_0000, 4'h4, 4'h4, 1'b1, 8'h33, TRL,  2'd2));
        if (TRL) tbl.push_back(mk(4'h0, 32'h0, 4'h0, 4'h0, 1'b1, 8'h03, 1'b0, 2'd2));
        tbl.push_back(mk(4'h0, 32'h0000_0000, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd2));
        tbl.push_back(mk(4'h2, 32'h0000_AA00, 4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 2'd1));
        tbl.push_back(mk(4'h2, 32'h0000_AA00, 4'h0, 4'h0, 1'b1, 8'hA1, 1'b1, 2'd1));
        tbl.push_back(mk(4'h2, 32'h0000_AA00, 4'h0, 4'h2, 1'b1, 8'hAA, 1'b1, 2'd1));
        tbl.push_back(mk(4'h2, 32'h0000_BB00, 4'h0, 4'h2, 1'b1, 8'hBB, 1'b1, 2'd1));
        tbl.push_back(mk(4'h8, 32'h0000_0000, 4'h0, 4'h0, 1'b0, 8'h00, TRL,  2'd1));
        if (TRL) tbl.push_back(mk(4'h8, 32'h0, 4'h0, 4'h0, 1'b1, 8'h02, 1'b0, 2'd1));
        tbl.push_back(mk(4'h8, 32'h0000_0000, 4'h0, 4'h0, 1'b0, 8'h00, 1'b1, 2'd3));
        tbl.push_back(mk(4'h8, 32'h0000_0000, 4'h0, 4'h0, 1'b1, 8'hA3, 1'b1, 2'd3));
        tbl.push_back(mk(4'h0, 32'h0000_0000, 4'h0, 4'h0, 1'b0, 8'h00, TRL,  2'd3));
        tbl.push_back(mk(4'h0, 32'h0000_0000, 4'h0, 4'h0, TRL,  8'h00, 1'b0, 2'd3));

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            #1;
            checkOutput($sformatf("vec%0d.src_ack", i), ack, tbl[i].exp_ack);
            tick();
            checkOutput($sformatf("vec%0d.fifo_write", i), fw, tbl[i].exp_wr);
            if (tbl[i].exp_wr) checkOutput($sformatf("vec%0d.fifo_data", i), fd, tbl[i].exp_data);
            checkOutput($sformatf("vec%0d.busy", i), bsy, tbl[i].exp_busy);
            checkOutput($sformatf("vec%0d.grant_id", i), gid, tbl[i].exp_gid);
        end

        // Space limit: one byte short of a full burst blocks, exactly enough grants.
        addr_in = 11'd2030;
        addr_out_sync = 11'(TRL);
        src_valid = 4'h1; src_data = 32'h0000_005A; src_last = 4'h0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("space.short%0d.busy", c), bsy, 0);
            checkOutput($sformatf("space.short%0d.fifo_write", c), fw, 0);
        end
        addr_out_sync = 11'(TRL) + 11'd1;
        tick();
        checkOutput("space.ok.busy", bsy, 1);
        checkOutput("space.ok.grant_id", gid, 0);
        checkOutput("space.ok.fifo_write", fw, 0);
        tick();
        checkOutput("space.ok.hdr_write", fw, 1);
        checkOutput("space.ok.hdr_data", fd, 8'hA0);
        src_valid = 4'h0;
        repeat (3) tick();
        addr_in = 11'd5;
        addr_out_sync = 11'd23;
        src_valid = 4'h1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("space.wrap%0d.busy", c), bsy, 0);
        end
        src_valid = 4'h0;
        addr_in = 11'd0;
        addr_out_sync = 11'd0;
        tick();

        // Reset asserted after two payload bytes of a source 2 burst.
        src_valid = 4'h4; src_data = 32'h0077_0000;
        repeat (4) tick();
        checkOutput("rst.pre.fifo_data", fd, 8'h77);
        checkOutput("rst.pre.busy", bsy, 1);
        reset = 1'b1;
        #1;
        checkOutput("rst.cycle.src_ack", ack, 0);
        tick();
        checkOutput("rst.after.fifo_write", fw, 0);
        checkOutput("rst.after.busy", bsy, 0);
        checkOutput("rst.after.grant_id", gid, 0);
        checkOutput("rst.after.src_ack", ack, 0);
        reset = 1'b0;
        src_valid = 4'hF;
        tick();
        checkOutput("rst.first.grant_id", gid, 0);
        checkOutput("rst.first.busy", bsy, 1);
        tick();
        checkOutput("rst.first.hdr", fd, 8'hA0);

        // Round-robin rotation on the BURST_MAX=4 instance with all sources requesting.
        resetBoth();
        src_valid = 4'hF; src_data = 32'h4433_2211; src_last = 4'h0;
        got_q.delete(); exp_q.delete();
        for (int b = 0; b < 5; b++) begin
            logic [7:0] pb;
            pb = 8'h11 * 8'((b % 4) + 1);
            exp_q.push_back(8'hA0 | 8'(b % 4));
            repeat (4) exp_q.push_back(pb);
            if (TRL) exp_q.push_back(8'h04);
        end
        for (int c = 0; c < 80 && got_q.size() < exp_q.size(); c++) begin
            tick();
            if (fw4) got_q.push_back(fd4);
        end
        src_valid = 4'h0;
        compareQueues("rr");

        // Source 3 five-byte burst ended by src_last.
        resetBoth();
        pay6[0] = 8'h31; pay6[1] = 8'h32; pay6[2] = 8'h33; pay6[3] = 8'h34; pay6[4] = 8'h35;
        got_q.delete(); exp_q.delete();
        exp_q.push_back(8'hA3);
        for (int i = 0; i < 5; i++) exp_q.push_back(pay6[i]);
        if (TRL) exp_q.push_back(8'h05);
        k = 0;
        src_valid = 4'h8;
        for (int c = 0; c < 20 && k < 5; c++) begin
            src_data = {pay6[k], 24'h0};
            src_last = (k == 4) ? 4'h8 : 4'h0;
            #1;
            acked = ack[3];
            tickCollect();
            if (acked) k++;
        end
        src_valid = 4'h0; src_last = 4'h0;
        repeat (4) tickCollect();
        compareQueues("trl");
        checkOutput("trl.busy_end", bsy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
